pixel_writer: RTL

Downstream stage of the triangle point generator. Each cycle the generator may emit a point write, and it has no stall input. This block buffers the accepted points in a FIFO, clips them to the screen, converts each one to a linear framebuffer address, and issues one memory write per pixel over a request/acknowledge handshake. It reports completion of a triangle once the generator is done and every buffered pixel has been written.

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 70 +++++++
 rtl/pixel_writer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants and types for the triangle raster pipeline.
package gpu_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned ADDR_W        = 19;
  localparam int unsigned COLOR_W       = 8;
  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned PIX_CNT_W     = 20;
  localparam int unsigned COORD_W       = 16;
  localparam int unsigned POINT_W       = 2 * COORD_W;

  typedef enum logic {
    S_PW_IDLE  = 1'b0,
    S_PW_WRITE = 1'b1
  } pw_state_e;

  // Generator point word: y in the upper half, x in the lower half.
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered occupancy; head entry is read combinationally.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers clipped generator points and issues one framebuffer write per pixel
// over a request/acknowledge handshake.
module pixel_writer
  import gpu_pkg::POINT_W, gpu_pkg::PIX_CNT_W;
#(
  parameter int unsigned SCREEN_WIDTH  = gpu_pkg::SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = gpu_pkg::SCREEN_HEIGHT,
  parameter int unsigned ADDR_W        = gpu_pkg::ADDR_W,
  parameter int unsigned COLOR_W       = gpu_pkg::COLOR_W,
  parameter int unsigned FIFO_DEPTH    = gpu_pkg::FIFO_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [COLOR_W-1:0]   i_color,
  input  logic                 i_write,
  input  logic [POINT_W-1:0]   i_point,
  input  logic                 i_gen_done,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [COLOR_W-1:0]   o_mem_data,
  input  logic                 i_mem_ack,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [PIX_CNT_W-1:0] o_pix_count
);

  import gpu_pkg::COORD_W;
  import gpu_pkg::point_t;
  import gpu_pkg::pw_state_e;
  import gpu_pkg::S_PW_IDLE;
  import gpu_pkg::S_PW_WRITE;

  localparam logic [PIX_CNT_W-1:0] PIX_CNT_MAX = '1;

  pw_state_e                 state_q, state_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0]        mem_data_q, mem_data_d;
  logic [COLOR_W-1:0]        color_q, color_d;
  logic                      overflow_q, overflow_d;
  logic [PIX_CNT_W-1:0]      pix_count_q, pix_count_d;

  point_t                    in_pt, head_pt;
  logic                      in_screen, push_req, load_head;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [POINT_W-1:0]        fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]         head_addr;

  // Input clip: off-screen points never reach the FIFO.
  assign in_pt     = point_t'(i_point);
  assign in_screen = (in_pt.x < COORD_W'(SCREEN_WIDTH)) && (in_pt.y < COORD_W'(SCREEN_HEIGHT));
  assign push_req  = i_write && in_screen;

  assign head_pt   = point_t'(fifo_rdata);
  assign head_addr = ADDR_W'(head_pt.y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(head_pt.x);

  pixel_fifo #(
    .WIDTH (POINT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push_req),
    .wdata   (i_point),
    .pop     (fifo_pop),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    color_d     = color_q;
    overflow_d  = overflow_q;
    pix_count_d = pix_count_q;
    fifo_pop    = 1'b0;
    load_head   = 1'b0;

    case (state_q)
      S_PW_IDLE: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
          state_d   = S_PW_WRITE;
        end
      end
      S_PW_WRITE: begin
        if (i_mem_ack) begin
          if (pix_count_q != PIX_CNT_MAX) begin
            pix_count_d = pix_count_q + PIX_CNT_W'(1);
          end
          if (!fifo_empty) begin
            load_head = 1'b1;
          end else begin
            mem_we_d = 1'b0;
            state_d  = S_PW_IDLE;
          end
        end
      end
      default: state_d = S_PW_IDLE;
    endcase

    if (load_head) begin
      fifo_pop   = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = head_addr;
      mem_data_d = color_q;
    end

    if (push_req && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end

    // A new triangle clears status even when it lands on an ack cycle.
    if (i_start) begin
      overflow_d  = 1'b0;
      pix_count_d = '0;
      color_d     = i_color;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_PW_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      color_q     <= '0;
      overflow_q  <= 1'b0;
      pix_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      color_q     <= color_d;
      overflow_q  <= overflow_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_overflow  = overflow_q;
  assign o_pix_count = pix_count_q;
  assign o_done      = i_gen_done && (fifo_count == '0) && (state_q == S_PW_IDLE) && !mem_we_q;

endmodule
